// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine with the architectural
// HI/LO registers. Shift-add multiply and restoring divide, one bit per cycle.
// Optional build macro: MULDIV_EARLY_OUT_EN lets a multiply leave CALC as soon
// as the remaining multiplier bits are zero; division always runs full length.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_data_i,
    input  logic [WIDTH-1:0] rt_data_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] mt_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = 6;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
    typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic             neg_a_q, neg_a_d;   // rs operand was negative (signed ops)
    logic             neg_b_q, neg_b_d;   // rt operand was negative (signed ops)
    logic [WIDTH-1:0] opa_q, opa_d;       // |rs|: multiplicand, or dividend/quotient shifter
    logic [WIDTH-1:0] opb_q, opb_d;       // |rt|: multiplier shifter, or divisor
    logic [WIDTH-1:0] rs_raw_q, rs_raw_d; // unmodified rs, returned in HI on divide by zero
    logic [2*WIDTH-1:0] acc_q, acc_d;     // product accumulator
    logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Per-cycle datapath steps and the sign-corrected results used in FIX.
    logic             start_signed;
    logic             start_neg_a, start_neg_b;
    logic [WIDTH:0]   mul_upper;
    logic [WIDTH:0]   div_trial;
    logic [2*WIDTH-1:0] prod_abs, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic             sign_diff;

    assign start_signed = ~op_i[0];
    assign start_neg_a  = start_signed & rs_data_i[WIDTH-1];
    assign start_neg_b  = start_signed & rt_data_i[WIDTH-1];
    assign sign_diff    = neg_a_q ^ neg_b_q;

    // Add the multiplicand into the upper half when the current multiplier bit is set.
    assign mul_upper = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opb_q[0] ? {1'b0, opa_q} : '0);

    // Shift the next dividend bit into the remainder and try subtracting the divisor;
    // the top bit of the difference is the borrow (trial negative -> restore).
    assign div_trial = {rem_q, opa_q[WIDTH-1]} - {1'b0, opb_q};

`ifdef MULDIV_EARLY_OUT_EN
    // An early exit leaves the product cnt_q positions too far left; realign it.
    assign prod_abs = acc_q >> cnt_q;
`else
    assign prod_abs = acc_q;
`endif
    assign prod_fix = sign_diff ? -prod_abs : prod_abs;
    assign quo_fix  = sign_diff ? -opa_q : opa_q;
    assign rem_fix  = neg_a_q ? -rem_q : rem_q;

    // Next-state, datapath and HI/LO update logic.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it
        // unassigned; a missing default would infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rs_raw_d = rs_raw_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // MTHI/MTLO only land while idle; a simultaneous start is also
                // taken, and its result overwrites HI/LO later.
                if (hi_we_i) hi_d = mt_data_i;
                if (lo_we_i) lo_d = mt_data_i;
                if (start_i) begin
                    op_d     = op_e'(op_i);
                    neg_a_d  = start_neg_a;
                    neg_b_d  = start_neg_b;
                    opa_d    = start_neg_a ? -rs_data_i : rs_data_i;
                    opb_d    = start_neg_b ? -rt_data_i : rt_data_i;
                    rs_raw_d = rs_data_i;
                    acc_d    = '0;
                    rem_d    = '0;
                    cnt_d    = CW'(WIDTH);
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end

            CALC: begin
                cnt_d = cnt_q - 1'b1;
                if (op_q[1]) begin
                    if (!div_trial[WIDTH]) begin
                        rem_d = div_trial[WIDTH-1:0];
                        opa_d = {opa_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[WIDTH-2:0], opa_q[WIDTH-1]};
                        opa_d = {opa_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_upper, acc_q[WIDTH-1:1]};
                    opb_d = opb_q >> 1;
                end
                if (cnt_d == '0) state_d = FIX;
`ifdef MULDIV_EARLY_OUT_EN
                if (!op_q[1] && opb_d == '0) state_d = FIX;
`endif
            end

            FIX: begin
                if (!op_q[1]) begin
                    hi_d = op_q[0] ? prod_abs[2*WIDTH-1:WIDTH] : prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = op_q[0] ? prod_abs[WIDTH-1:0]       : prod_fix[WIDTH-1:0];
                end else if (opb_q == '0) begin
                    lo_d = '1;
                    hi_d = rs_raw_q;
                end else begin
                    lo_d = op_q[0] ? opa_q : quo_fix;
                    hi_d = op_q[0] ? rem_q : rem_fix;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MULT;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            rs_raw_q <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            rs_raw_q <= rs_raw_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed testbench for mips_muldiv_unit. Expected latencies follow the
// MULDIV_EARLY_OUT_EN build macro when it is defined for the bench as well.
module tb_mips_muldiv_unit;

    localparam int WIDTH = 32;
    localparam int BOUND = 100;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] rs_data_i;
    logic [WIDTH-1:0] rt_data_i;
    logic             hi_we_i;
    logic             lo_we_i;
    logic [WIDTH-1:0] mt_data_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    int n_tests = 0;
    int n_fail  = 0;

    mips_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .op_i      (op_i),
        .rs_data_i (rs_data_i),
        .rt_data_i (rt_data_i),
        .hi_we_i   (hi_we_i),
        .lo_we_i   (lo_we_i),
        .mt_data_i (mt_data_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for done_o. Returns the number of
    // edges from the start edge to the edge that raised done_o, and the number of
    // cycles busy_o was seen high in between. Operand inputs are scrambled after
    // the start edge since the unit must have latched them.
    task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output int edges, output int busy_cycles);
        @(negedge clk);
        start_i   = 1'b1;
        op_i      = op;
        rs_data_i = rs;
        rt_data_i = rt;
        @(posedge clk);
        #1;
        start_i   = 1'b0;
        rs_data_i = $urandom;
        rt_data_i = $urandom;
        edges       = 0;
        busy_cycles = 0;
        while (!done_o && edges < BOUND) begin
            if (busy_o) busy_cycles++;
            @(posedge clk);
            #1;
            edges++;
        end
        check("done_seen", {63'd0, done_o}, 64'd1);
    endtask

    int edges, busy_cycles, done_count;

    initial begin
        rst_n     = 1'b0;
        start_i   = 1'b0;
        op_i      = 2'd0;
        rs_data_i = '0;
        rt_data_i = '0;
        hi_we_i   = 1'b0;
        lo_we_i   = 1'b0;
        mt_data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hi",   64'(hi_o), 64'd0);
        check("rst_lo",   64'(lo_o), 64'd0);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        rst_n = 1'b1;

        // MULTU all-ones squared, full-length timing
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, busy_cycles);
        check("multu_hi",    64'(hi_o), 64'hFFFF_FFFE);
        check("multu_lo",    64'(lo_o), 64'h0000_0001);
        check("multu_edges", 64'(edges), 64'd33);
        check("multu_busy",  64'(busy_cycles), 64'd33);
        check("multu_busy_low", {63'd0, busy_o}, 64'd0);

        // MULT -3 * 7 (start accepted in the done cycle of the previous op)
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, edges, busy_cycles);
        check("mult_hi", 64'(hi_o), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo_o), 64'hFFFF_FFEB);
`ifdef MULDIV_EARLY_OUT_EN
        check("mult_edges", 64'(edges), 64'd4);
`else
        check("mult_edges", 64'(edges), 64'd33);
`endif

        // MULT 5 * -4 = -20
        run_op(2'd0, 32'd5, 32'hFFFF_FFFC, edges, busy_cycles);
        check("mult2_hi", 64'(hi_o), 64'hFFFF_FFFF);
        check("mult2_lo", 64'(lo_o), 64'hFFFF_FFEC);

        // DIV -7 / 2 -> q=-3, r=-1
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, edges, busy_cycles);
        check("div_lo",    64'(lo_o), 64'hFFFF_FFFD);
        check("div_hi",    64'(hi_o), 64'hFFFF_FFFF);
        check("div_edges", 64'(edges), 64'd33);

        // DIV 7 / -2 -> q=-3, r=+1 (remainder follows dividend)
        run_op(2'd2, 32'd7, 32'hFFFF_FFFE, edges, busy_cycles);
        check("div2_lo", 64'(lo_o), 64'hFFFF_FFFD);
        check("div2_hi", 64'(hi_o), 64'h0000_0001);

        // DIVU 100 / 7 -> 14 r 2
        run_op(2'd3, 32'd100, 32'd7, edges, busy_cycles);
        check("divu_lo", 64'(lo_o), 64'd14);
        check("divu_hi", 64'(hi_o), 64'd2);

        // DIV signed overflow
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, edges, busy_cycles);
        check("ovf_lo", 64'(lo_o), 64'h8000_0000);
        check("ovf_hi", 64'(hi_o), 64'd0);

        // DIVU by zero
        run_op(2'd3, 32'h0000_1234, 32'd0, edges, busy_cycles);
        check("divu0_lo", 64'(lo_o), 64'hFFFF_FFFF);
        check("divu0_hi", 64'(hi_o), 64'h0000_1234);

        // DIV by zero with negative dividend: HI keeps the raw dividend
        run_op(2'd2, 32'hFFFF_FFFB, 32'd0, edges, busy_cycles);
        check("div0_lo", 64'(lo_o), 64'hFFFF_FFFF);
        check("div0_hi", 64'(hi_o), 64'hFFFF_FFFB);

        // MTHI / MTLO in IDLE
        @(negedge clk);
        hi_we_i   = 1'b1;
        mt_data_i = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
        hi_we_i = 1'b0;
        check("mthi", 64'(hi_o), 64'hA5A5_A5A5);
        @(negedge clk);
        lo_we_i   = 1'b1;
        mt_data_i = 32'h5A5A_5A5A;
        @(posedge clk);
        #1;
        lo_we_i = 1'b0;
        check("mtlo", 64'(lo_o), 64'h5A5A_5A5A);

        // MULTU 3 * 0x80000001 with MTLO and start pulsed mid-CALC
        @(negedge clk);
        start_i   = 1'b1;
        op_i      = 2'd1;
        rs_data_i = 32'd3;
        rt_data_i = 32'h8000_0001;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start_i   = 1'b1;
        lo_we_i   = 1'b1;
        op_i      = 2'd3;
        rs_data_i = 32'd100;
        rt_data_i = 32'd7;
        mt_data_i = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        lo_we_i = 1'b0;
        edges   = 5;
        check("midcalc_hi",   64'(hi_o), 64'hA5A5_A5A5);
        check("midcalc_lo",   64'(lo_o), 64'h5A5A_5A5A);
        check("midcalc_busy", {63'd0, busy_o}, 64'd1);
        while (!done_o && edges < BOUND) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("mid_done_seen", {63'd0, done_o}, 64'd1);
        check("mid_edges", 64'(edges), 64'd33);
        check("mid_hi", 64'(hi_o), 64'h0000_0001);
        check("mid_lo", 64'(lo_o), 64'h8000_0003);
        @(posedge clk);
        #1;
        check("no_queue_busy", {63'd0, busy_o}, 64'd0);
        check("no_queue_done", {63'd0, done_o}, 64'd0);

        // Reset at E10 of a DIVU aborts it
        @(negedge clk);
        start_i   = 1'b1;
        op_i      = 2'd3;
        rs_data_i = 32'd100;
        rt_data_i = 32'd7;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_hi",   64'(hi_o), 64'd0);
        check("abort_lo",   64'(lo_o), 64'd0);
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        done_count = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_o) done_count++;
        end
        check("abort_no_done", 64'(done_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
